// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity modes and parity helper for the oversampling UART receiver
package uart_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP = 3'd4;
  localparam state_t S_BRK_WAIT = 3'd5;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD = 2;
  function automatic logic parity_exp(input logic [8:0] v, input int mode);
    return mode == PARITY_ODD ? ~^v : mode == PARITY_EVEN ? ^v : 1'b0;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: line synchroniser, start-edge detector and 3-sample majority voter
module uart_rx_sync #(
  parameter int OVERSAMPLE = 16,
  parameter int CW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          serial_in_i,
  input  logic [CW-1:0] sample_cnt_i,
  output logic          sin_s_o,
  output logic          fall_o,
  output logic          vote_o
);
  localparam int M = OVERSAMPLE / 2;
  logic meta_q, sin_q, prev_q, vote_q;
  logic [1:0] samp_q;
  // All flops idle high so a reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sin_q <= 1'b1;
      prev_q <= 1'b1;
      samp_q <= 2'b11;
      vote_q <= 1'b1;
    end else begin
      meta_q <= serial_in_i;
      sin_q <= meta_q;
      prev_q <= sin_q;
      if (sample_cnt_i == CW'(M - 1)) samp_q[0] <= sin_q;
      if (sample_cnt_i == CW'(M)) samp_q[1] <= sin_q;
      if (sample_cnt_i == CW'(M + 1)) vote_q <= (samp_q[0] & samp_q[1]) | (sin_q & (samp_q[0] | samp_q[1]));
    end
  end
  assign sin_s_o = sin_q;
  assign fall_o = prev_q & ~sin_q;
  assign vote_o = vote_q;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with parity, break detection,
// sticky error flags and a read-acknowledge handshake
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sample_clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 rd_ack,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_reg,
  output logic                 not_ready_out,
  output logic                 error1,
  output logic                 error2,
  output logic                 error3,
  output logic                 break_det
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M = OVERSAMPLE / 2;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_pend_q, par_pend_d, par_bit_q, par_bit_d;
  logic nr_q, nr_d, e1_q, e1_d, e2_q, e2_d, e3_q, e3_d, brk_q, brk_d;
  logic sin_s, fall, vote, vote_pt, wrap, done, ferr, brk, load;
  uart_rx_sync #(.OVERSAMPLE(OVERSAMPLE), .CW(CW)) u_sync (
    .clk(sample_clk),
    .rst(rst),
    .serial_in_i(serial_in),
    .sample_cnt_i(cnt_q),
    .sin_s_o(sin_s),
    .fall_o(fall),
    .vote_o(vote)
  );
  assign vote_pt = cnt_q == CW'(M + 2);
  assign wrap = cnt_q == CW'(OVERSAMPLE - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_pend_d = par_pend_q;
    par_bit_d = par_bit_q;
    done = 1'b0;
    ferr = 1'b0;
    brk = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          bit_d = '0;
          par_pend_d = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      S_START: state_d = (vote_pt && vote) ? S_IDLE : wrap ? S_DATA : S_START;
      S_DATA: begin
        if (vote_pt) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            state_d = PARITY_MODE != PARITY_NONE ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (vote_pt) begin
          par_bit_d = vote;
          par_pend_d = vote != parity_exp(9'(shift_q), PARITY_MODE);
        end
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        // A low first stop bit after an all-zero frame is a break, not a framing error
        if (vote_pt && !vote) begin
          brk = bit_q == '0 && shift_q == '0 && !par_bit_q;
          ferr = !brk;
          state_d = brk ? S_BRK_WAIT : S_IDLE;
        end else if (vote_pt && bit_q == BW'(STOP_BITS - 1)) begin
          done = 1'b1;
          state_d = S_IDLE;
        end else if (wrap) begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_BRK_WAIT: state_d = sin_s ? S_IDLE : S_BRK_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  assign load = done & (nr_q | rd_ack);
  assign data_d = load ? shift_q : data_q;
  assign nr_d = load ? 1'b0 : rd_ack ? 1'b1 : nr_q;
  assign e1_d = (done & ~load) | (e1_q & ~err_clr);
  assign e2_d = ferr | (e2_q & ~err_clr);
  assign e3_d = (load & par_pend_q) | (e3_q & ~err_clr);
  assign brk_d = brk | (brk_q & ~err_clr);
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      par_pend_q <= 1'b0;
      par_bit_q <= 1'b0;
      nr_q <= 1'b1;
      e1_q <= 1'b0;
      e2_q <= 1'b0;
      e3_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      par_pend_q <= par_pend_d;
      par_bit_q <= par_bit_d;
      nr_q <= nr_d;
      e1_q <= e1_d;
      e2_q <= e2_d;
      e3_q <= e3_d;
      brk_q <= brk_d;
    end
  end
  assign data_reg = data_q;
  assign not_ready_out = nr_q;
  assign error1 = e1_q;
  assign error2 = e2_q;
  assign error3 = e3_q;
  assign break_det = brk_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames (8 data bits, even parity, 1 stop, 16x oversampling)
module tb_uart_rx_param;
  logic clk = 1'b0, rst = 1'b1, serial_in = 1'b1, rd_ack = 1'b0, err_clr = 1'b0;
  logic [7:0] data_reg;
  logic not_ready_out, error1, error2, error3, break_det, nr_prev = 1'b1;
  logic [3:0] flags;
  int checks = 0, errors = 0, nr_falls = 0;
  assign flags = {error1, error2, error3, break_det};
  always #5 clk = ~clk;
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut (
    .sample_clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .rd_ack(rd_ack),
    .err_clr(err_clr),
    .data_reg(data_reg),
    .not_ready_out(not_ready_out),
    .error1(error1),
    .error2(error2),
    .error3(error3),
    .break_det(break_det)
  );
  always @(negedge clk) begin
    if (nr_prev && !not_ready_out) nr_falls++;
    nr_prev = not_ready_out;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic ack, input logic clr);
    @(negedge clk);
    rd_ack = ack;
    err_clr = clr;
    @(negedge clk);
    rd_ack = 1'b0;
    err_clr = 1'b0;
  endtask
  // Frame = start, d[0..7], parity, stop; ack raises rd_ack exactly on the completion cycle
  task automatic send(input logic [7:0] d, input logic p, input logic stp, input logic ack, input int ncyc);
    logic [10:0] f;
    f = {stp, p, d, 1'b0};
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      serial_in = f[i/16];
      rd_ack = ack && i == 173;
    end
    @(negedge clk);
    serial_in = 1'b1;
    rd_ack = 1'b0;
  endtask
  initial begin
    idle(3);
    chk("rst_data", 32'(data_reg), 32'h0);
    chk("rst_nr", 32'(not_ready_out), 32'h1);
    chk("rst_flags", 32'(flags), 32'h0);
    rst = 1'b0;
    idle(20);
    send(8'hA5, 1'b0, 1'b1, 1'b0, 176);
    idle(20);
    chk("a5_data", 32'(data_reg), 32'hA5);
    chk("a5_nr", 32'(not_ready_out), 32'h0);
    chk("a5_flags", 32'(flags), 32'h0);
    chk("a5_falls", 32'(nr_falls), 32'h1);
    pulse(1'b1, 1'b0);
    chk("ack_nr", 32'(not_ready_out), 32'h1);
    repeat (4) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    @(negedge clk);
    serial_in = 1'b1;
    idle(40);
    chk("glitch_nr", 32'(not_ready_out), 32'h1);
    chk("glitch_flags", 32'(flags), 32'h0);
    chk("glitch_data", 32'(data_reg), 32'hA5);
    send(8'h3C, 1'b1, 1'b1, 1'b0, 176);
    idle(20);
    chk("par_data", 32'(data_reg), 32'h3C);
    chk("par_nr", 32'(not_ready_out), 32'h0);
    chk("par_flags", 32'(flags), 32'h2);
    pulse(1'b1, 1'b1);
    chk("clr_flags", 32'(flags), 32'h0);
    chk("clr_nr", 32'(not_ready_out), 32'h1);
    send(8'h11, 1'b0, 1'b0, 1'b0, 176);
    idle(20);
    chk("frm_flags", 32'(flags), 32'h4);
    chk("frm_data", 32'(data_reg), 32'h3C);
    chk("frm_nr", 32'(not_ready_out), 32'h1);
    pulse(1'b0, 1'b1);
    repeat (192) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    chk("brk_flags", 32'(flags), 32'h1);
    chk("brk_data", 32'(data_reg), 32'h3C);
    chk("brk_nr", 32'(not_ready_out), 32'h1);
    @(negedge clk);
    serial_in = 1'b1;
    idle(32);
    send(8'h5A, 1'b0, 1'b1, 1'b0, 176);
    idle(20);
    chk("post_brk_data", 32'(data_reg), 32'h5A);
    chk("post_brk_flags", 32'(flags), 32'h1);
    pulse(1'b1, 1'b1);
    send(8'h01, 1'b1, 1'b1, 1'b0, 176);
    idle(20);
    chk("ovr1_data", 32'(data_reg), 32'h01);
    send(8'h02, 1'b1, 1'b1, 1'b0, 176);
    idle(20);
    chk("ovr_data", 32'(data_reg), 32'h01);
    chk("ovr_flags", 32'(flags), 32'h8);
    chk("ovr_nr", 32'(not_ready_out), 32'h0);
    send(8'h03, 1'b0, 1'b1, 1'b1, 176);
    idle(20);
    chk("ackld_data", 32'(data_reg), 32'h03);
    chk("ackld_nr", 32'(not_ready_out), 32'h0);
    chk("ackld_flags", 32'(flags), 32'h8);
    send(8'h55, 1'b0, 1'b1, 1'b0, 69);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_data", 32'(data_reg), 32'h0);
    chk("mrst_nr", 32'(not_ready_out), 32'h1);
    chk("mrst_flags", 32'(flags), 32'h0);
    rst = 1'b0;
    idle(32);
    send(8'h7E, 1'b0, 1'b1, 1'b0, 176);
    idle(20);
    chk("7e_data", 32'(data_reg), 32'h7E);
    chk("7e_nr", 32'(not_ready_out), 32'h0);
    chk("7e_flags", 32'(flags), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
